// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the config write sequencer.
// The unchanged-nibble skip option is selected with CFG_SEQ_SKIP_UNCHANGED_EN.
package cfg_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2
    } cfg_seq_state_t;

    // bit7=1 tells the config register there is no write this cycle
    localparam logic [7:0]  CFG_IDLE_BYTE    = 8'h80;
    localparam logic [31:0] CFG_DEFAULT_WORD = 32'hBBFC_0000;
    localparam int          NIBBLES          = 8;

    // Write byte format understood by the config register: {0, addr, nibble}
    function automatic logic [7:0] mk_wr_byte(input logic [2:0] addr, input logic [3:0] nib);
        return {1'b0, addr, nib};
    endfunction

endpackage

// File: rtl/cfg_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after ptr, wrapping modulo NUM_REQ.
module cfg_rr_arbiter
    import cfg_seq_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         gnt_idx,
    output logic               gnt_any
);

    // Two passes: indices at/after ptr first, then the wrapped low indices.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && (i >= int'(ptr)) && req[i]) begin
                gnt_any = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req[i]) begin
                gnt_any = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/config_write_sequencer.sv
// Shares the config register nibble-write port among NUM_REQ requesters.
// A granted 32-bit word is serialised as eight {0,addr,nibble} bytes and
// one flush byte; shadow_cfg tracks the committed register value.
// Optional feature: CFG_SEQ_SKIP_UNCHANGED_EN suppresses writes of nibbles
// that already match the shadow (slot timing is unchanged).
//
// Handshake: req_valid[i] may rise or fall at any time before grant. A
// request is accepted in the IDLE cycle where req_ready[i] is high; the
// word on req_data[i] is sampled at that clock edge only. req_ready is
// one-hot or zero, and zero whenever a word is in flight.
module config_write_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int          NUM_REQ     = 2,
    parameter logic [31:0] CFG_DEFAULT = CFG_DEFAULT_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             cfg_byte_out,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             done_id,
    output logic [31:0]            shadow_cfg,
    output logic [1:0]             state_dbg
);

    cfg_seq_state_t state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    word_q;
    logic [2:0]     id_q;
    logic [2:0]     rr_ptr;
    logic [7:0]     last_wr_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [2:0]         arb_idx;
    logic               arb_any;
    logic [31:0]        req_word;

    logic [7:0] byte_d;
    logic       busy_d;
    logic       done_d;
    logic       grant;

    cfg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
    assign state_dbg = state_q;

    // Byte for nibble slot a of word w; an unchanged nibble may become a no-write
    function automatic logic [7:0] nib_byte(input logic [31:0] w, input logic [2:0] a);
        logic [3:0] n;
        n = w[{a, 2'b00} +: 4];
`ifdef CFG_SEQ_SKIP_UNCHANGED_EN
        if (n == shadow_cfg[{a, 2'b00} +: 4]) begin
            return CFG_IDLE_BYTE;
        end
`endif
        return mk_wr_byte(a, n);
    endfunction

    // Select the granted requester's word
    always_comb begin
        req_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                req_word = req_data[32*i +: 32];
            end
        end
    end

    // Next state and next registered outputs; the output register shows the
    // byte for the slot the FSM is entering, so byte k lands at t+1+k.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = CFG_IDLE_BYTE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant   = 1'b1;
                    state_d = WRITE;
                    idx_d   = 3'd0;
                    byte_d  = nib_byte(req_word, 3'd0);
                    busy_d  = 1'b1;
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                if (idx_q == 3'(NIBBLES - 1)) begin
                    state_d = FLUSH;
                    byte_d  = last_wr_q;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + 3'd1;
                    byte_d = nib_byte(word_q, idx_q + 3'd1);
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, slot counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            cfg_byte_out <= CFG_IDLE_BYTE;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_id      <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cfg_byte_out <= byte_d;
            busy         <= busy_d;
            done         <= done_d;
            if (done_d) begin
                done_id <= id_q;
            end
        end
    end

    // Grant capture, round-robin pointer and last-written byte tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q    <= CFG_DEFAULT;
            id_q      <= 3'd0;
            rr_ptr    <= 3'd0;
            last_wr_q <= CFG_IDLE_BYTE;
        end else if (grant) begin
            word_q    <= req_word;
            id_q      <= arb_idx;
            rr_ptr    <= (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
            last_wr_q <= byte_d;
        end else if (state_d == WRITE && !byte_d[7]) begin
            last_wr_q <= byte_d;
        end
    end

    // Shadow follows the register: updated as the flush byte is applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_cfg <= CFG_DEFAULT;
        end else if (state_q == FLUSH) begin
            shadow_cfg <= word_q;
        end
    end

endmodule

// File: tb/tb_config_write_sequencer.sv
// Self-checking bench for config_write_sequencer: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_config_write_sequencer;

    localparam int N = 2;
`ifdef CFG_SEQ_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     cfg_byte_out;
    logic           busy;
    logic           done;
    logic [2:0]     done_id;
    logic [31:0]    shadow_cfg;
    logic [1:0]     state_dbg;

    always #5 clk = ~clk;

    config_write_sequencer #(.NUM_REQ(N), .CFG_DEFAULT(32'hBBFC_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cfg_byte_out (cfg_byte_out),
        .busy         (busy),
        .done         (done),
        .done_id      (done_id),
        .shadow_cfg   (shadow_cfg),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    int          m_phase;      // 0 idle, k = k-th cycle after grant
    int          m_ptr;
    logic [31:0] m_shadow;
    logic [31:0] m_word;
    int          m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_phase  = 0;
        m_ptr    = 0;
        m_shadow = 32'hBBFC_0000;
        m_word   = 32'h0;
        m_id     = 0;
    endtask

    // Expected byte stream for one word: 8 slot bytes then the flush byte
    task automatic build_bytes(input logic [31:0] w);
        logic [7:0] last;
        logic [3:0] n;
        logic [3:0] s;
        last = 8'h80;
        for (int i = 0; i < 8; i++) begin
            n = 4'((w >> (4 * i)) & 32'hF);
            s = 4'((m_shadow >> (4 * i)) & 32'hF);
            if (SKIP && n == s) begin
                exp_q.push_back(8'h80);
            end else begin
                exp_q.push_back(8'(i * 16 + int'(n)));
                last = 8'(i * 16 + int'(n));
            end
        end
        exp_q.push_back(last);
    endtask

    // Compare one cycle of DUT outputs with the model, then advance it
    task automatic check_cycle();
        logic [N-1:0] exp_ready;
        logic [7:0]   eb;
        int           g;
        exp_ready = '0;
        g = -1;
        check("shadow", shadow_cfg, m_shadow);
        if (m_phase == 0) begin
            check("idle_byte", 32'(cfg_byte_out), 32'h80);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_done", 32'(done), 32'h0);
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("ready", 32'(req_ready), 32'(exp_ready));
            if (g >= 0) begin
                m_word = req_data[32*g +: 32];
                m_id   = g;
                m_ptr  = (g + 1) % N;
                build_bytes(m_word);
                m_phase = 1;
            end
        end else begin
            check("busy_ready", 32'(req_ready), 32'h0);
            check("busy", 32'(busy), 32'h1);
            eb = 8'h80;
            if (exp_q.size() > 0) eb = exp_q.pop_front();
            check("byte", 32'(cfg_byte_out), 32'(eb));
            check("done", 32'(done), (m_phase == 9) ? 32'h1 : 32'h0);
            if (m_phase == 9) begin
                check("done_id", 32'(done_id), 32'(m_id));
                m_shadow = m_word;
                m_phase  = 0;
            end else begin
                m_phase++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [N-1:0] v, input logic [32*N-1:0] d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step('0, req_data);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return m_shadow;
            1: return m_shadow ^ (32'h1 << (4 * $urandom_range(0, 7)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [32*N-1:0] d;
        logic [31:0]     w;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        m_reset();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_byte", 32'(cfg_byte_out), 32'h80);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_done_id", 32'(done_id), 32'h0);
        check("rst_shadow", shadow_cfg, 32'hBBFC_0000);
        check("rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cycle();

        // Quiet bus stays idle
        idle(5);

        // Single word from requester 0
        d = '0;
        d[31:0] = 32'h1234_5678;
        step(2'b01, d);
        step(2'b00, d);
        check("first_byte", 32'(cfg_byte_out), 32'h08);
        idle(9);
        check("shadow_1234", shadow_cfg, 32'h1234_5678);

        // Both requesters continuously valid: grants must alternate
        for (int i = 0; i < 40; i++) begin
            d = {$urandom, $urandom};
            step(2'b11, d);
        end
        idle(10);

        // One changed nibble, then an identical word
        w = (m_shadow & ~32'h0000_F000) | 32'h0000_A000;
        d = {32'h0, w};
        step(2'b01, d);
        idle(10);
        d = {m_shadow, 32'h0};
        step(2'b10, d);
        idle(10);

        // Reset in the middle of a word
        d = {32'h0, 32'hCAFE_F00D};
        step(2'b01, d);
        idle(5);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_byte", 32'(cfg_byte_out), 32'h80);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_shadow", shadow_cfg, 32'hBBFC_0000);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_cycle();
        d = {32'h0, 32'h0F0F_0F0F};
        step(2'b01, d);
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < N; r++) d[32*r +: 32] = rand_word();
            step(N'($urandom_range(0, (1 << N) - 1)), d);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
